// File: rtl/stream_demux.sv
// stream_demux: 1-to-NUM_OUT valid/ready demux, select locked per packet,
// one holding stage; bad-select packets are discarded and counted.
// Ports: clk, rst (sync, high); in_data/in_sel/in_last/in_valid/in_ready;
// out_data (lane k at [k*DATA_W +: DATA_W]), out_last, out_valid,
// out_ready per lane; drop_cnt counts dropped packets (saturating).
module stream_demux #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_last,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_last,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [15:0]               drop_cnt
);

  if ((2 ** SEL_W) < NUM_OUT) begin : g_sel_chk
    $error("stream_demux: SEL_W too small for NUM_OUT");
  end
  if (NUM_OUT < 2 || NUM_OUT > 16) begin : g_num_chk
    $error("stream_demux: NUM_OUT must be 2..16");
  end

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } state_t;

  localparam logic [SEL_W:0] LANES = (SEL_W+1)'(NUM_OUT);

  state_t              state;
  logic                hv;
  logic [DATA_W-1:0]   hd;
  logic                hl;
  logic [SEL_W-1:0]    hdst;
  logic                xfer;
  logic                sel_ok;
  logic                drain;

  assign drain    = hv && out_ready[hdst];
  assign in_ready = (state == DROP) || !hv || out_ready[hdst];
  assign xfer     = in_valid && in_ready;
  assign sel_ok   = {1'b0, in_sel} < LANES;

  always_comb begin
    out_data  = '0;
    out_last  = '0;
    out_valid = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (hv && hdst == SEL_W'(k)) begin
        out_data[k*DATA_W +: DATA_W] = hd;
        out_last[k]  = hl;
        out_valid[k] = 1'b1;
      end
    end
  end

  // hdst doubles as the locked destination while in FWD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hv       <= 1'b0;
      hd       <= '0;
      hl       <= 1'b0;
      hdst     <= '0;
      drop_cnt <= '0;
    end else begin
      if (drain) hv <= 1'b0;
      if (xfer) begin
        unique case (state)
          IDLE: begin
            if (sel_ok) begin
              hv    <= 1'b1;
              hd    <= in_data;
              hl    <= in_last;
              hdst  <= in_sel;
              state <= in_last ? IDLE : FWD;
            end else begin
              if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
              state <= in_last ? IDLE : DROP;
            end
          end
          FWD: begin
            hv    <= 1'b1;
            hd    <= in_data;
            hl    <= in_last;
            state <= in_last ? IDLE : FWD;
          end
          DROP: begin
            state <= in_last ? IDLE : DROP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed tests for stream_demux, 4-lane instance plus
// a 3-lane instance for the bad-select drop path.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_valid3 = 1'b0;
  logic        in_ready, in_ready3;
  logic [31:0] out_data;
  logic [23:0] out_data3;
  logic [3:0]  out_last, out_valid, out_ready = '0;
  logic [2:0]  out_last3, out_valid3, out_ready3 = '0;
  logic [15:0] drop_cnt, drop_cnt3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_demux #(.DATA_W(8), .NUM_OUT(4), .SEL_W(2)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  stream_demux #(.DATA_W(8), .NUM_OUT(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_last(in_last), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_last(out_last3), .out_valid(out_valid3),
    .out_ready(out_ready3), .drop_cnt(drop_cnt3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h55; in_last = 1'b1;
    out_ready = 4'hF; rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL reset_valid got %h exp 0", out_valid); end
      checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL reset_drop got %h exp 0", drop_cnt); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
    end
    in_valid = 1'b0; rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    tick();
    checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL reset_noforward got %h exp 0", out_valid); end
  endtask

  task automatic test_sweep();
    logic [31:0] ed;
    out_ready = 4'hF; in_last = 1'b1; in_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s); in_data = 8'hA0 + 8'(s);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready%0d got %b exp 1", s, in_ready); end
      tick();
      ed = 32'(8'hA0 + 8'(s)) << (8 * s);
      checks++; if (out_valid !== 4'(1 << s)) begin errors++; $display("FAIL sweep_valid%0d got %h exp %h", s, out_valid, 4'(1 << s)); end
      checks++; if (out_data !== ed) begin errors++; $display("FAIL sweep_data%0d got %h exp %h", s, out_data, ed); end
      checks++; if (out_last !== 4'(1 << s)) begin errors++; $display("FAIL sweep_last%0d got %h exp %h", s, out_last, 4'(1 << s)); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL sweep_drain got %h exp 0", out_valid); end
  endtask

  task automatic test_select_lock();
    out_ready = 4'hF; in_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      in_sel = (b == 0) ? 2'd2 : 2'd1;
      in_data = 8'hC0 + 8'(b); in_last = (b == 3);
      tick();
      checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL lock_valid%0d got %h exp 4", b, out_valid); end
      checks++; if (out_data !== (32'(8'hC0 + 8'(b)) << 16)) begin errors++; $display("FAIL lock_data%0d got %h exp %h", b, out_data, 32'(8'hC0 + 8'(b)) << 16); end
      checks++; if (out_last !== ((b == 3) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL lock_last%0d got %h", b, out_last); end
    end
    in_sel = 2'd0; in_data = 8'hD0; in_last = 1'b1;
    tick();
    checks++; if (out_valid !== 4'b0001) begin errors++; $display("FAIL lock_newsel got %h exp 1", out_valid); end
    checks++; if (out_data !== 32'h0000_00D0) begin errors++; $display("FAIL lock_newdata got %h exp d0", out_data); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 4'hF; in_valid = 1'b1; in_sel = 2'd1;
    in_data = 8'hE0; in_last = 1'b0;
    tick();
    out_ready = 4'b1101; in_data = 8'hE1; in_sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %b exp 0", i, in_ready); end
      tick();
      checks++; if (out_valid !== 4'b0010 || out_data !== 32'h0000_E000) begin errors++; $display("FAIL bp_hold%0d got %h/%h exp 2/0000e000", i, out_valid, out_data); end
    end
    out_ready = 4'hF;
    for (int b = 1; b < 4; b++) begin
      in_data = 8'hE0 + 8'(b); in_last = (b == 3);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_rel_ready%0d got %b exp 1", b, in_ready); end
      tick();
      checks++; if (out_valid !== 4'b0010 || out_data !== (32'(8'hE0 + 8'(b)) << 8)) begin errors++; $display("FAIL bp_seq%0d got %h/%h", b, out_valid, out_data); end
    end
    checks++; if (out_last !== 4'b0010) begin errors++; $display("FAIL bp_last got %h exp 2", out_last); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL bp_drain got %h exp 0", out_valid); end
  endtask

  task automatic test_drop();
    out_ready3 = 3'b111; in_valid3 = 1'b1; in_sel = 2'd3;
    checks++; if (drop_cnt3 !== 16'd0) begin errors++; $display("FAIL drop_init got %h exp 0", drop_cnt3); end
    for (int b = 0; b < 3; b++) begin
      in_data = 8'h70 + 8'(b); in_last = (b == 2);
      if (b == 1) out_ready3 = 3'b000;
      #1;
      checks++; if (in_ready3 !== 1'b1) begin errors++; $display("FAIL drop_ready%0d got %b exp 1", b, in_ready3); end
      tick();
      checks++; if (out_valid3 !== 3'b000) begin errors++; $display("FAIL drop_valid%0d got %h exp 0", b, out_valid3); end
      checks++; if (drop_cnt3 !== 16'd1) begin errors++; $display("FAIL drop_cnt%0d got %h exp 1", b, drop_cnt3); end
    end
    out_ready3 = 3'b111; in_sel = 2'd0; in_data = 8'h5A; in_last = 1'b1;
    tick();
    checks++; if (out_valid3 !== 3'b001 || out_data3 !== 24'h00005A) begin errors++; $display("FAIL drop_after got %h/%h exp 1/00005a", out_valid3, out_data3); end
    checks++; if (drop_cnt3 !== 16'd1) begin errors++; $display("FAIL drop_after_cnt got %h exp 1", drop_cnt3); end
    in_valid3 = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    out_ready = 4'hF; in_valid = 1'b1; in_sel = 2'd3; in_last = 1'b0;
    in_data = 8'h30;
    tick();
    in_data = 8'h31; in_sel = 2'd0;
    tick();
    checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL mr_pre got %h exp 8", out_valid); end
    in_data = 8'h32; rst = 1'b1;
    tick();
    checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL mr_rst got %h exp 0", out_valid); end
    rst = 1'b0; in_sel = 2'd0; in_data = 8'h40; in_last = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_ready got %b exp 1", in_ready); end
    tick();
    checks++; if (out_valid !== 4'b0001 || out_data !== 32'h0000_0040) begin errors++; $display("FAIL mr_lane0 got %h/%h exp 1/00000040", out_valid, out_data); end
    in_valid = 1'b0;
    tick();
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL mr_drop got %h exp 0", drop_cnt); end
  endtask

  initial begin
    #2;
    test_reset();
    test_sweep();
    test_select_lock();
    test_backpressure();
    test_drop();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parametrised 1-to-NUM_OUT stream demultiplexer with valid/ready handshakes on the input and on every output.
- The destination is sampled on the first beat of a packet and held until the last beat.
- Output is registered: one holding stage, 1-cycle latency, full throughput of 1 beat/cycle.
- Packets addressed to a non-existent output are consumed, discarded and counted.
- Sits between a single producer and NUM_OUT consumer lanes; successor to the fixed 1-bit, 4-way combinational demux.

Parameters:
- DATA_W, 8: payload width per beat.
- NUM_OUT, 4: number of output lanes, 2..16.
- SEL_W, 2: select width; 2**SEL_W >= NUM_OUT is required. Elaboration fails via $error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  input payload.
- in_sel  input  SEL_W  destination lane; only sampled on the first beat of a packet.
- in_last  input  1  marks the final beat of a packet.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts a beat this cycle.
- out_data  output  NUM_OUT*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- out_last  output  NUM_OUT  per-lane last flag.
- out_valid  output  NUM_OUT  per-lane valid; at most one bit set.
- out_ready  input  NUM_OUT  per-lane consumer ready.
- drop_cnt  output  16  count of dropped packets.

Behaviour:
- One clock, synchronous active-high reset. On rst=1 at a clk edge:
  - state=IDLE; holding register empty.
  - out_valid=0, out_last=0, out_data=0, drop_cnt=0.
  - in_ready evaluates to 1 in the cycle after reset.
- Input transfer occurs when in_valid && in_ready. Output transfer on lane k occurs when out_valid[k] && out_ready[k].
- Holding register fields: hv (valid), hd (data), hl (last), hdst (lane).
  - Lane hdst drives hd / hl / hv.
  - All other lanes drive data=0, last=0, valid=0.
- in_ready (combinational):
  - State DROP: 1.
  - Otherwise: !hv || out_ready[hdst].
  - in_ready never depends on in_valid.
- State machine, advancing on input transfers only:
  - IDLE, in_sel < NUM_OUT: lock dst=in_sel and load the holding register. Go to FWD if in_last=0; stay in IDLE if in_last=1 (single-beat packet).
  - IDLE, in_sel >= NUM_OUT: beat is discarded and drop_cnt increments. Go to DROP if in_last=0; stay in IDLE if in_last=1.
  - FWD: each beat loads the holding register with the locked dst; in_sel is ignored. The beat with in_last=1 returns to IDLE.
  - DROP: beats are discarded and in_sel is ignored. The beat with in_last=1 returns to IDLE.
- Holding register update:
  - Load on input transfer.
  - Otherwise clear hv when lane hdst transfers.
  - Drain and refill in the same cycle yields back-to-back beats with no bubble.
- Latency: an accepted beat appears on its lane the next cycle.
- Once out_valid is asserted, data/last/valid hold stable until accepted (AXI-stream rule).
- drop_cnt increments once per dropped packet, not per beat, and saturates at 16'hFFFF.
- A new packet to a different lane may be accepted while the previous last beat is still held, provided the held beat drains that cycle; otherwise it stalls.
- Reset mid-packet:
  - Held beat is lost.
  - The next accepted beat after reset is treated as a first beat, so in_sel is sampled.
- out_ready on non-addressed lanes has no effect.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, drop_cnt=0, no beat is forwarded; in_ready=1 after release.
- Sweep lanes: single-beat packets with in_sel=0..3, data=8'hA0+sel, all out_ready=1 -> exactly lane sel shows valid one cycle later with that data; other lanes read 0.
- Select lock: 4-beat packet, in_sel=2 on beat 0 and in_sel=1 on beats 1-3 -> all 4 beats appear on lane 2 in order, out_last[2] only on beat 4; the state then accepts a new select.
- Backpressure: out_ready[1]=0 for 3 cycles during a lane-1 packet -> in_ready=0, held beat stable; release -> no loss or duplication, 1 beat/cycle thereafter.
- Drop: NUM_OUT=3, 3-beat packet with in_sel=3 -> in_ready=1 throughout, no out_valid, drop_cnt goes 0->1; a following in_sel=0 packet is forwarded normally.
- Mid-packet reset: rst during beat 2 of a lane-3 packet, then a beat with in_sel=0, in_last=1 -> beat appears on lane 0 only.
